// File: rtl/jtdd_mcu_com_if.sv
// Main-CPU and MCU bus signals of the Double Dragon com bridge, grouped for port use.
// The bridge takes the slave view; whatever drives the CPU buses takes the master view.
interface jtdd_mcu_com_if;
    // Main CPU side
    logic       main_cen;
    logic       com_cs;
    logic [8:0] main_AB;
    logic       main_RnW;
    logic [7:0] main_dout;
    logic [7:0] mcu_ram;
    logic       mcu_nmi_set;
    logic       mcu_halt;
    logic       mcu_rstb;
    logic       mcu_ban;
    logic       mcu_irqmain;
    // MCU side
    logic       mcu_cen;
    logic [8:0] mcu_addr;
    logic       mcu_shared_cs;
    logic       mcu_wr;
    logic [7:0] mcu_dout;
    logic [7:0] mcu_shared_din;
    logic       mcu_nmi;
    logic       mcu_nmi_ack;
    logic       mcu_irq_cs;
    logic       mcu_haltn;
    logic       mcu_ba;
    logic       mcu_rst;

    modport slave (
        input  main_cen, com_cs, main_AB, main_RnW, main_dout,
        input  mcu_nmi_set, mcu_halt, mcu_rstb,
        input  mcu_cen, mcu_addr, mcu_shared_cs, mcu_wr, mcu_dout,
        input  mcu_nmi_ack, mcu_irq_cs, mcu_ba,
        output mcu_ram, mcu_ban, mcu_irqmain,
        output mcu_shared_din, mcu_nmi, mcu_haltn, mcu_rst
    );

    modport master (
        output main_cen, com_cs, main_AB, main_RnW, main_dout,
        output mcu_nmi_set, mcu_halt, mcu_rstb,
        output mcu_cen, mcu_addr, mcu_shared_cs, mcu_wr, mcu_dout,
        output mcu_nmi_ack, mcu_irq_cs, mcu_ba,
        input  mcu_ram, mcu_ban, mcu_irqmain,
        input  mcu_shared_din, mcu_nmi, mcu_haltn, mcu_rst
    );
endinterface

// File: rtl/jtdd_mcu_com.sv
// Double Dragon main-CPU <-> HD63701 bridge: 512x8 shared com RAM, NMI latch,
// main IRQ pulse stretcher, MCU reset register and the halt / bus-available handshake.
module jtdd_mcu_com #(
    parameter int unsigned IRQ_LEN = 8
) (
    input  logic           clk,
    input  logic           rstn,
    jtdd_mcu_com_if.slave  bus
);

    localparam logic [7:0] IRQ_LOAD = 8'(IRQ_LEN);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REQ    = 2'd1,
        ST_HALTED = 2'd2,
        ST_REL    = 2'd3
    } halt_state_e;

    logic       main_we;
    logic       mcu_we;
    logic [7:0] mem [512];
    logic [7:0] main_rd_q;
    logic [7:0] mcu_rd_q;

    logic       nmi_set_q;
    logic       nmi_q, nmi_d;
    logic       nmi_edge;
    logic       nmi_ack;

    logic [7:0] irq_cnt_q, irq_cnt_d;
    logic       irq_trig;

    logic       rst_q;

    halt_state_e state_q, state_d;
    logic        haltn_q, haltn_d;
    logic        ban_q, ban_d;

    assign main_we  = bus.com_cs & ~bus.main_RnW & bus.main_cen;
    assign mcu_we   = bus.mcu_shared_cs & bus.mcu_wr & bus.mcu_cen;
    assign nmi_edge = bus.mcu_nmi_set & ~nmi_set_q;
    assign nmi_ack  = bus.mcu_nmi_ack & bus.mcu_cen;
    assign irq_trig = bus.mcu_irq_cs & bus.mcu_wr & bus.mcu_cen;

    // NOTE: the RAM array has no reset; clearing it would defeat block-RAM mapping
    // and its contents are meaningless until software writes them anyway.
    always_ff @(posedge clk) begin
        if (mcu_we) begin
            mem[bus.mcu_addr] <= bus.mcu_dout;
        end
        // NOTE: with non-blocking assignments the last one scheduled wins, so the
        // main write placed second takes priority on a same-address collision.
        if (main_we) begin
            mem[bus.main_AB] <= bus.main_dout;
        end
    end

    // Registered read ports: a read colliding with a write returns the old byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_rd_q <= 8'h00;
            mcu_rd_q  <= 8'h00;
        end else begin
            main_rd_q <= mem[bus.main_AB];
            mcu_rd_q  <= mem[bus.mcu_addr];
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        nmi_d     = nmi_q;
        irq_cnt_d = irq_cnt_q;
        if (!bus.mcu_rstb) begin
            nmi_d     = 1'b0;
            irq_cnt_d = 8'd0;
        end else begin
            if (nmi_edge) begin
                nmi_d = 1'b1;
            end else if (nmi_ack) begin
                nmi_d = 1'b0;
            end
            // A retrigger reloads, so overlapping requests stretch one pulse.
            if (irq_trig) begin
                irq_cnt_d = IRQ_LOAD;
            end else if (irq_cnt_q != 8'd0) begin
                irq_cnt_d = irq_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nmi_set_q <= 1'b0;
            nmi_q     <= 1'b0;
            irq_cnt_q <= 8'd0;
            rst_q     <= 1'b1;
        end else begin
            nmi_set_q <= bus.mcu_nmi_set;
            nmi_q     <= nmi_d;
            irq_cnt_q <= irq_cnt_d;
            rst_q     <= ~bus.mcu_rstb;
        end
    end

    // Halt handshake: request HALT, wait for BA, hold, release, wait for BA to drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (bus.mcu_halt) state_d = ST_REQ;
            ST_REQ: begin
                if (bus.mcu_ba) begin
                    state_d = ST_HALTED;
                end else if (!bus.mcu_halt) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: if (!bus.mcu_halt) state_d = ST_REL;
            ST_REL:    if (!bus.mcu_ba) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
        if (!bus.mcu_rstb) begin
            state_d = ST_RUN;
        end
        haltn_d = (state_d == ST_RUN) || (state_d == ST_REL);
        ban_d   = bus.mcu_rstb && ((state_d == ST_RUN) || (state_d == ST_REQ));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RUN;
            haltn_q <= 1'b1;
            ban_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            haltn_q <= haltn_d;
            ban_q   <= ban_d;
        end
    end

    assign bus.mcu_ram        = main_rd_q;
    assign bus.mcu_shared_din = mcu_rd_q;
    assign bus.mcu_nmi        = nmi_q;
    assign bus.mcu_irqmain    = (irq_cnt_q != 8'd0);
    assign bus.mcu_rst        = rst_q;
    assign bus.mcu_haltn      = haltn_q;
    assign bus.mcu_ban        = ban_q;

endmodule

// File: doc/jtdd_mcu_com.md
# jtdd_mcu_com

MCU-side communication bridge for the Double Dragon main-CPU ↔ HD63701 MCU link. It owns the 512-byte shared "com" RAM, which is dual-ported between the main CPU and the MCU. It also terminates the main CPU's NMI-set, halt and reset requests toward the MCU, and returns the bus-available status (`mcu_ban`) and the MCU-originated IRQ (`mcu_irqmain`) to the main CPU. It sits between the main CPU block and the MCU core, all on the single system clock.

## Interface
- `IRQ_LEN`, default 8: width of the `mcu_irqmain` pulse, in `clk` cycles (1..255).
- `clk`  in  1  system clock; every register in the block uses it.
- `rstn`  in  1  asynchronous, active-low reset.
- `main_cen`  in  1  main CPU clock enable; main-side writes are sampled only when it is high.
- `com_cs`  in  1  main CPU selects the shared RAM.
- `main_AB`  in  9  main CPU address bits [8:0].
- `main_RnW`  in  1  main CPU read/not-write.
- `main_dout`  in  8  main CPU write data.
- `mcu_ram`  out  8  shared RAM read data returned to the main CPU.
- `mcu_nmi_set`  in  1  main request for an MCU NMI; a level that may stay high for several cycles.
- `mcu_halt`  in  1  main request to halt the MCU; a level.
- `mcu_rstb`  in  1  MCU run enable; low holds the MCU in reset.
- `mcu_ban`  out  1  high while the MCU owns its bus; low when the MCU is halted or in reset.
- `mcu_irqmain`  out  1  IRQ pulse to the main CPU.
- `mcu_cen`  in  1  MCU clock enable.
- `mcu_addr`  in  9  MCU address bits [8:0] within the shared window.
- `mcu_shared_cs`  in  1  MCU selects the shared RAM.
- `mcu_wr`  in  1  MCU write strobe.
- `mcu_dout`  in  8  MCU write data.
- `mcu_shared_din`  out  8  shared RAM read data returned to the MCU.
- `mcu_nmi`  out  1  NMI line to the MCU.
- `mcu_nmi_ack`  in  1  MCU access to the NMI-acknowledge port.
- `mcu_irq_cs`  in  1  MCU write to the main-IRQ port.
- `mcu_haltn`  out  1  HALT pin to the MCU, active-low.
- `mcu_ba`  in  1  bus-available output of the MCU.
- `mcu_rst`  out  1  reset line to the MCU.

## Operation
- **Shared RAM:** 512x8, true dual port.
  - Main side writes when `com_cs & ~main_RnW & main_cen`.
  - MCU side writes when `mcu_shared_cs & mcu_wr & mcu_cen`.
  - Both read ports are registered: `mcu_ram` and `mcu_shared_din` update one cycle after the address changes.
  - If both sides write the same address in the same cycle, the main CPU's data is stored.
  - If one side reads an address the other side writes in the same cycle, the reader gets the old data.
- **NMI:**
  - A rising edge of `mcu_nmi_set` (compared against a registered copy) sets `mcu_nmi`.
  - `mcu_ack` handling: `mcu_nmi_ack & mcu_cen` clears `mcu_nmi`.
  - If a set edge and an ack happen in the same cycle, set wins.
  - A `mcu_nmi_set` level held high does not re-trigger the NMI.
- **Main IRQ:**
  - `mcu_irq_cs & mcu_wr & mcu_cen` loads an 8-bit down-counter with `IRQ_LEN`.
  - `mcu_irqmain` = counter ≠ 0.
  - A new trigger while the pulse is active reloads the counter, so the pulse is extended, not doubled.
- **Reset control:** `mcu_rst` = `~mcu_rstb`, registered.
- **Halt FSM**, states RUN, REQ, HALTED, REL:
  - RUN: `mcu_haltn`=1, `mcu_ban`=1. Goes to REQ when `mcu_halt`=1.
  - REQ: `mcu_haltn`=0, `mcu_ban`=1. Goes to HALTED when `mcu_ba`=1. Goes to RUN if `mcu_halt` drops first.
  - HALTED: `mcu_haltn`=0, `mcu_ban`=0. Goes to REL when `mcu_halt`=0.
  - REL: `mcu_haltn`=1, `mcu_ban`=0. Goes to RUN when `mcu_ba`=0.
  - While `mcu_rstb`=0: the FSM is forced to RUN, `mcu_ban`=0, and `mcu_nmi` and the IRQ counter are cleared. On `mcu_rstb` rising, `mcu_ban` returns to 1 on the next cycle.
- **Reset values** (while `rstn`=0):
  - `mcu_nmi`=0, `mcu_irqmain`=0, `mcu_haltn`=1, `mcu_ban`=0, `mcu_rst`=1.
  - FSM = RUN, edge register = 0.
  - `mcu_ram`=`mcu_shared_din`=8'h00; RAM contents are undefined.

## Timing
- `mcu_nmi` rises 1 cycle after the `mcu_nmi_set` edge and falls 1 cycle after the qualified ack.
- `mcu_irqmain` rises 1 cycle after the qualified trigger and stays high exactly `IRQ_LEN` cycles.
- Every FSM transition takes 1 cycle. `mcu_haltn` and `mcu_ban` are registered outputs of the state.
- If `rstn` is asserted mid-operation (during a halt, NMI or IRQ pulse), all outputs return to their reset values immediately and asynchronously. After reset, operation resumes from RUN.

## Test plan
- **Shared RAM:** main writes 8'h5A to 9'h1FF; MCU reads 9'h1FF → `mcu_shared_din`=8'h5A one cycle later. In the same cycle, main writes 8'h11 and MCU writes 8'h22 to 9'h010 → main reads 8'h11.
- **NMI:** hold `mcu_nmi_set` high for 5 cycles → `mcu_nmi` rises once. Ack → `mcu_nmi` falls. Set edge and ack in the same cycle → `mcu_nmi` stays 1.
- **IRQ pulse** (`IRQ_LEN`=8): a single MCU IRQ write → `mcu_irqmain` high for 8 cycles. A second write 3 cycles in → high for 11 cycles in total.
- **Halt handshake:** `mcu_halt`=1 → `mcu_haltn`=0 next cycle. `mcu_ba`=1 → `mcu_ban`=0. `mcu_halt`=0 → `mcu_haltn`=1. `mcu_ba`=0 → `mcu_ban`=1. Abort case: `mcu_halt` drops while in REQ → back to RUN with `mcu_ban` never low.
- **`mcu_rstb` low in HALTED:** `mcu_rst`=1, FSM goes to RUN, `mcu_ban`=0, `mcu_nmi`=0. On `mcu_rstb` rising → `mcu_ban`=1 on the next cycle.
- **`rstn` pulse during an IRQ pulse:** `mcu_irqmain`=0 immediately. After release, no residual pulse.
